intc_sequencer: RTL and testbench

INTC_SEQUENCER -- requirements
Module: intc_sequencer

---
 rtl/intc_pkg.sv | 21 ++
 rtl/intc_prio_enc.sv | 17 +
 rtl/intc_sequencer.sv | 155 +++++++++++++++
 tb/tb_intc_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM states,
// the opcodes that block an issue, and the default vector base.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [5:0]  RET_OP           = 6'b010000;
  localparam logic [2:0]  JMP_CLASS        = 3'b011;
  localparam logic [15:0] VEC_BASE_DEFAULT = 16'hF000;
  localparam int          NEST_DEPTH       = 3;

  // An interrupt may not be taken while a jump or return owns the PC path.
  function automatic logic op_blocks_irq(input logic [5:0] op);
    return (op[5:3] == JMP_CLASS) || (op == RET_OP);
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// 4-to-2 fixed-priority encoder, bit 0 wins; vld flags a non-empty request set.
module intc_prio_enc (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       vld
);

  always_comb begin
    idx = 2'd0;
    vld = |req;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
  end

endmodule

// File: rtl/intc_sequencer.sv
// Interrupt sequencer: edge-detects 4 sources, masks, prioritises and issues a
// one-cycle vectored interrupt; define INTC_NESTING_EN for preemption with a 3-deep stack.
module intc_sequencer
  import intc_pkg::*;
#(
  parameter logic [15:0] VEC_BASE  = VEC_BASE_DEFAULT,
  parameter int          VEC_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_req,
  input  logic        mask_wr,
  input  logic [3:0]  mask_data,
  input  logic [5:0]  op,
  output logic        interrupt,
  output logic [15:0] vector,
  output logic        irq_active,
  output logic [1:0]  irq_id,
  output logic [3:0]  pending
);

  state_e     state_q, state_d;
  logic [3:0] irq_s_q, irq_s_d;
  logic [3:0] irq_p_q, irq_p_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] irq_id_q, irq_id_d;

  logic [3:0] eligible;
  logic [1:0] win_idx;
  logic       win_vld;
  logic       blocked;
  logic       launch;

  assign eligible = pending_q & ~mask_q;
  assign blocked  = op_blocks_irq(op);

  intc_prio_enc u_prio_enc (
    .req (eligible),
    .idx (win_idx),
    .vld (win_vld)
  );

`ifdef INTC_NESTING_EN
  logic [1:0] stk_q [NEST_DEPTH];
  logic [1:0] stk_d [NEST_DEPTH];
  logic [1:0] stk_cnt_q, stk_cnt_d;
  logic       push, pop;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
`ifdef INTC_NESTING_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld && !blocked) begin
          state_d = ST_ISSUE;
          launch  = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_SERVICE;
      ST_SERVICE: begin
`ifdef INTC_NESTING_EN
        if (op == RET_OP) begin
          if (stk_cnt_q != 2'd0) pop = 1'b1;
          else                   state_d = ST_IDLE;
        end else if (win_vld && !blocked && (win_idx < irq_id_q)) begin
          state_d = ST_ISSUE;
          launch  = 1'b1;
          push    = 1'b1;
        end
`else
        if (op == RET_OP) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    interrupt  = (state_q == ST_ISSUE);
    irq_active = (state_q != ST_IDLE);
    irq_id     = irq_id_q;
    pending    = pending_q;
    vector     = interrupt ? (VEC_BASE + (16'(irq_id_q) << VEC_SHIFT)) : 16'h0000;
  end

  // Two-stage sample: a rise seen at one edge lands in pending on the next.
  always_comb begin
    irq_s_d   = irq_req;
    irq_p_d   = irq_s_q;
    mask_d    = mask_wr ? mask_data : mask_q;
    pending_d = pending_q;
    if (launch) pending_d[win_idx] = 1'b0;
    pending_d = pending_d | (irq_s_q & ~irq_p_q);
    irq_id_d  = irq_id_q;
    if (launch) irq_id_d = win_idx;
`ifdef INTC_NESTING_EN
    else if (pop) irq_id_d = stk_q[stk_cnt_q - 2'd1];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s_q   <= 4'h0;
      irq_p_q   <= 4'h0;
      pending_q <= 4'h0;
      mask_q    <= 4'hF;
      irq_id_q  <= 2'd0;
    end else begin
      irq_s_q   <= irq_s_d;
      irq_p_q   <= irq_p_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_id_q  <= irq_id_d;
    end
  end

`ifdef INTC_NESTING_EN
  always_comb begin
    stk_d     = stk_q;
    stk_cnt_d = stk_cnt_q;
    if (push && (stk_cnt_q != 2'd3)) begin
      stk_d[stk_cnt_q] = irq_id_q;
      stk_cnt_d        = stk_cnt_q + 2'd1;
    end else if (pop) begin
      stk_cnt_d = stk_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_cnt_q <= 2'd0;
      for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= 2'd0;
    end else begin
      stk_cnt_q <= stk_cnt_d;
      stk_q     <= stk_d;
    end
  end

  // Only four priority levels exist, so at most three ids are ever saved.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                  push |-> (stk_cnt_q != 2'd3));
`endif

endmodule

// File: tb/tb_intc_sequencer.sv
// Directed scenarios followed by random traffic, checked against a queue-based model.
module tb_intc_sequencer;

  localparam logic [15:0] VB  = 16'hF000;
  localparam int          VS  = 4;
  localparam logic [5:0]  RET = 6'b010000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  d_irq = 4'h0;
  logic        d_mwr = 1'b0;
  logic [3:0]  d_mdat = 4'h0;
  logic [5:0]  d_op = 6'h0;
  logic        interrupt;
  logic [15:0] vector;
  logic        irq_active;
  logic [1:0]  irq_id;
  logic [3:0]  pending;

  int n_vec = 0;
  int n_err = 0;

  intc_sequencer #(.VEC_BASE(VB), .VEC_SHIFT(VS)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_req    (d_irq),
    .mask_wr    (d_mwr),
    .mask_data  (d_mdat),
    .op         (d_op),
    .interrupt  (interrupt),
    .vector     (vector),
    .irq_active (irq_active),
    .irq_id     (irq_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Reference model: served[] is the stack of sources in service, top = current.
  logic [3:0] m_s1, m_s2, m_pend, m_mask;
  bit         m_iss;
  int         m_id;
  int         served[$];

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_pend = 0; m_mask = 4'hF;
    m_iss = 0; m_id = 0; served.delete();
  endtask

  task automatic model_edge();
    int         best;
    bit         blk;
    bit         take;
    logic [3:0] elig;
    bit         nest;
`ifdef INTC_NESTING_EN
    nest = 1;
`else
    nest = 0;
`endif
    best = -1;
    take = 0;
    elig = m_pend & ~m_mask;
    for (int i = 3; i >= 0; i--) if (elig[i]) best = i;
    blk = (d_op[5:3] == 3'b011) || (d_op == RET);
    if (m_iss) m_iss = 0;
    else if (served.size() == 0) take = (best >= 0) && !blk;
    else if (d_op == RET) begin
      void'(served.pop_back());
      if (served.size() > 0) m_id = served[$];
    end else if (nest && best >= 0 && !blk && best < served[$]) take = 1;
    if (take) begin
      served.push_back(best);
      m_id = best;
      m_iss = 1;
      m_pend[best] = 1'b0;
    end
    m_pend = m_pend | (m_s1 & ~m_s2);
    m_s2 = m_s1;
    m_s1 = d_irq;
    if (d_mwr) m_mask = d_mdat;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] ev;
    ev = m_iss ? 16'(VB + m_id * (1 << VS)) : 16'h0000;
    chk(tag, {8'h0, interrupt, vector, irq_active, irq_id, pending},
             {8'h0, m_iss, ev, served.size() > 0, 2'(m_id), m_pend});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic run_until_int(input string tag, input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      step(tag);
      n++;
      if (interrupt === 1'b1) break;
    end
  endtask

  int n;
  bit seen;

  initial begin
    #1;
    model_reset();
    check_model("reset_model");
    chk("reset_active", irq_active, 0);
    step("reset_hold");
    reset = 1'b0;

    // Single source, latency from sampled rise to pulse.
    d_mwr = 1; d_mdat = 4'h0; step("mask0"); d_mwr = 0;
    d_irq = 4'b0100;
    run_until_int("r036", 6, n);
    chk("r036_lat", n, 3);
    chk("r036_vec", vector, 16'hF020);
    chk("r036_id", irq_id, 2);
    chk("r036_pend", pending, 0);
    d_irq = 0; step("r036_svc");
    chk("r036_onepulse", interrupt, 0);
    d_op = RET; step("r036_ret"); d_op = 0;
    chk("r036_idle", irq_active, 0);

    // Two simultaneous sources, priority order.
    d_irq = 4'b1010;
    run_until_int("r037a", 6, n);
    chk("r037_id1", irq_id, 1);
    chk("r037_vec1", vector, 16'hF010);
    step("r037_svc");
    d_op = RET; step("r037_ret"); d_op = 0;
    run_until_int("r037b", 4, n);
    chk("r037_vec3", vector, 16'hF030);
    step("r037_svc2");
    d_op = RET; step("r037_ret2"); d_op = 0; d_irq = 0;
    step("r037_end");

    // Jump-class opcode holds off the issue.
    d_op = 6'b011100; d_irq = 4'b0001;
    seen = 0;
    for (int i = 0; i < 4; i++) begin step("r038_blk"); seen |= interrupt; end
    chk("r038_blocked", seen, 0);
    chk("r038_pend", pending, 4'b0001);
    d_op = 0; step("r038_go");
    chk("r038_int", interrupt, 1);
    chk("r038_vec", vector, 16'hF000);
    step("r038_svc");
    d_op = RET; step("r038_ret"); d_op = 0; d_irq = 0;

    // Masked request retained, issued on unmask.
    d_mwr = 1; d_mdat = 4'b0001; step("r039_mask"); d_mwr = 0;
    d_irq = 4'b0001; seen = 0;
    for (int i = 0; i < 4; i++) begin step("r039_msk"); seen |= interrupt; end
    chk("r039_noint", seen, 0);
    chk("r039_pend", pending, 4'b0001);
    d_mwr = 1; d_mdat = 4'h0; step("r039_unmask"); d_mwr = 0;
    run_until_int("r039_go", 4, n);
    chk("r039_lat", n, 1);
    chk("r039_vec", vector, 16'hF000);
    step("r039_svc");
    d_op = RET; step("r039_ret"); d_op = 0; d_irq = 0;
    step("r039_end");

    // Higher-priority request while serving source 3.
    d_irq = 4'b1000;
    run_until_int("r040a", 6, n);
    chk("r040_id3", irq_id, 3);
    step("r040_svc");
    d_irq = 4'b1001;
    run_until_int("r040_pre", 4, n);
`ifdef INTC_NESTING_EN
    chk("r040_preempt", interrupt, 1);
    chk("r040_id0", irq_id, 0);
    step("r040_svc0");
    d_op = RET; step("r040_ret1");
    chk("r040_back3", irq_id, 3);
    chk("r040_still", irq_active, 1);
    step("r040_ret2");
    chk("r040_idle", irq_active, 0);
    d_op = 0;
`else
    chk("r040_nopre", interrupt, 0);
    chk("r040_pend", pending, 4'b0001);
    d_op = RET; step("r040_ret"); d_op = 0;
    run_until_int("r040_b", 3, n);
    chk("r040_id0", irq_id, 0);
    chk("r040_vec0", vector, 16'hF000);
    step("r040_svc0");
    d_op = RET; step("r040_ret0"); d_op = 0;
`endif
    d_irq = 0; step("r040_end");

    // Asynchronous reset in the middle of a service.
    d_irq = 4'b0100;
    run_until_int("r041a", 6, n);
    step("r041_svc");
    chk("r041_insvc", irq_active, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_model("r041_async");
    chk("r041_outs", {interrupt, vector, irq_active, irq_id, pending}, 0);
    d_irq = 0;
    step("r041_hold"); step("r041_hold");
    reset = 1'b0;
    d_irq = 4'b0010; seen = 0;
    for (int i = 0; i < 6; i++) begin step("r041_after"); seen |= interrupt; end
    chk("r041_nopulse", seen, 0);
    chk("r041_maskF", pending, 4'b0010);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      d_irq  = d_irq ^ (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      d_mwr  = ($urandom_range(0, 11) == 0);
      d_mdat = 4'($urandom);
      case ($urandom_range(0, 7))
        0:       d_op = RET;
        1:       d_op = {3'b011, 3'($urandom)};
        default: d_op = 6'($urandom);
      endcase
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
